// File: rtl/pixclk_pkg.sv
// Shared constants for the NCO pixel-clock generator: default widths, the
// 50 MHz -> 6 MHz increment and the frame length used for the resync guard.
package pixclk_pkg;

   localparam int unsigned ACC_W_DEF     = 24;
   localparam int unsigned GUARD_W_DEF   = 24;
   localparam int unsigned INC_50M_TO_6M = 4026532;

   // (1944 active rows + 9 vertical-blank rows) x 3492 PIXCLK per row
   localparam int unsigned FRAME_ROWS      = 1944 + 9;
   localparam int unsigned ROW_PIXCLKS     = 3492;
   localparam int unsigned FRAME_PIXCLKS   = FRAME_ROWS * ROW_PIXCLKS;
   localparam int unsigned LOSS_PERIOD_DEF = 2 * FRAME_PIXCLKS;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser for an asynchronous level plus an edge flop; the rise
// strobe is formed only from flop outputs, so it carries no input path.
module sync_rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/pixclk_nco_resync.sv
// Fractional-NCO pixel clock with guarded phase realignment on frame-valid
// rising edges, plus early-edge reporting and lock tracking.
module pixclk_nco_resync
   import pixclk_pkg::*;
#(
   parameter int unsigned ACC_W           = ACC_W_DEF,
   parameter int unsigned GUARD_W         = GUARD_W_DEF,
   parameter int unsigned MIN_SYNC_PERIOD = FRAME_PIXCLKS,
   parameter int unsigned LOSS_PERIOD     = LOSS_PERIOD_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ACC_W-1:0] inc,
   input  logic             fv,
   input  logic             resync_en,
   output logic             pix_clk,
   output logic             pix_rise,
   output logic             pix_fall,
   output logic             realign,
   output logic             early,
   output logic [7:0]       early_count,
   output logic             locked
);

   localparam logic [GUARD_W-1:0] GUARD_MAX = '1;

   logic               fv_edge;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W:0]     sum;
   logic               carry;
   logic [GUARD_W-1:0] guard;
   logic               guard_ge_min;
   logic               guard_ge_loss;
   logic               accept;
   logic               reject;

   sync_rise_detect u_fv_sync (
      .clk   (clk),
      .reset (reset),
      .din   (fv),
      .rise  (fv_edge)
   );

   assign sum   = {1'b0, acc} + {1'b0, inc};
   assign carry = sum[ACC_W];

   // Compare at 32 bits so thresholds larger than the guard range still work.
   assign guard_ge_min  = (32'(guard) >= 32'(MIN_SYNC_PERIOD));
   assign guard_ge_loss = (32'(guard) >= 32'(LOSS_PERIOD));

   assign accept = fv_edge & resync_en & guard_ge_min;
   assign reject = fv_edge & resync_en & ~guard_ge_min;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc         <= '0;
         pix_clk     <= 1'b0;
         pix_rise    <= 1'b0;
         pix_fall    <= 1'b0;
         realign     <= 1'b0;
         early       <= 1'b0;
         early_count <= '0;
         locked      <= 1'b0;
         guard       <= '0;
      end else begin
         pix_rise <= 1'b0;
         pix_fall <= 1'b0;
         realign  <= 1'b0;
         early    <= 1'b0;
         if (accept) begin
            // Realignment overrides any carry landing in the same cycle.
            acc     <= '0;
            pix_clk <= 1'b0;
            guard   <= '0;
            realign <= 1'b1;
            locked  <= 1'b1;
         end else begin
            acc <= sum[ACC_W-1:0];
            if (carry) begin
               pix_clk  <= ~pix_clk;
               pix_rise <= ~pix_clk;
               pix_fall <= pix_clk;
               if (!pix_clk && (guard != GUARD_MAX)) begin
                  guard <= guard + 1'b1;
               end
            end
            if (locked && guard_ge_loss) begin
               locked <= 1'b0;
            end
            if (reject) begin
               early       <= 1'b1;
               early_count <= sat_inc8(early_count);
            end
         end
      end
   end

endmodule

// File: tb/tb_pixclk_nco_resync.sv
// Bench for pixclk_nco_resync: constant vector table, directed corner cases
// and a random phase, all also tracked by a cycle-level reference model.
module tb_pixclk_nco_resync;

   localparam int ACC_W     = 4;
   localparam int GUARD_W   = 8;
   localparam int MIN_SYNC  = 5;
   localparam int LOSS      = 10;
   localparam int ACC_MOD   = 1 << ACC_W;
   localparam int GUARD_MAX = (1 << GUARD_W) - 1;

   // ---------------- clock / reset / DUT ----------------
   logic             clk       = 1'b0;
   logic             reset     = 1'b1;
   logic [ACC_W-1:0] inc       = '0;
   logic             fv        = 1'b0;
   logic             resync_en = 1'b1;
   logic             pix_clk;
   logic             pix_rise;
   logic             pix_fall;
   logic             realign;
   logic             early;
   logic [7:0]       early_count;
   logic             locked;

   always #5 clk = ~clk;

   pixclk_nco_resync #(
      .ACC_W           (ACC_W),
      .GUARD_W         (GUARD_W),
      .MIN_SYNC_PERIOD (MIN_SYNC),
      .LOSS_PERIOD     (LOSS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .inc         (inc),
      .fv          (fv),
      .resync_en   (resync_en),
      .pix_clk     (pix_clk),
      .pix_rise    (pix_rise),
      .pix_fall    (pix_fall),
      .realign     (realign),
      .early       (early),
      .early_count (early_count),
      .locked      (locked)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   logic [13:0] exp_q[$];

   // reference model: phase as an integer modulo 2^ACC_W, level as carry parity
   int m_phase;
   int m_guard;
   int m_ecnt;
   bit m_clk, m_rise, m_fall, m_realign, m_early, m_locked;
   bit fv_hist[3];

   function automatic logic [13:0] dut_vec();
      return {pix_clk, pix_rise, pix_fall, realign, early, locked, early_count};
   endfunction

   function automatic logic [13:0] model_vec();
      return {m_clk, m_rise, m_fall, m_realign, m_early, m_locked, 8'(m_ecnt)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      bit evt;
      int s;
      if (reset) begin
         m_phase = 0; m_guard = 0; m_ecnt = 0;
         m_clk = 0; m_rise = 0; m_fall = 0; m_realign = 0; m_early = 0; m_locked = 0;
         fv_hist[0] = 0; fv_hist[1] = 0; fv_hist[2] = 0;
      end else begin
         // an fv rise is acted on two edges after it is first sampled
         evt = resync_en && fv_hist[1] && !fv_hist[2];
         m_rise = 0; m_fall = 0; m_realign = 0; m_early = 0;
         if (evt && m_guard >= MIN_SYNC) begin
            m_phase = 0; m_clk = 0; m_guard = 0; m_realign = 1; m_locked = 1;
         end else begin
            if (m_locked && m_guard >= LOSS) m_locked = 0;
            s = m_phase + int'(inc);
            m_phase = s % ACC_MOD;
            if (s >= ACC_MOD) begin
               m_clk = !m_clk;
               if (m_clk) begin
                  m_rise = 1;
                  if (m_guard < GUARD_MAX) m_guard++;
               end else begin
                  m_fall = 1;
               end
            end
            if (evt) begin
               m_early = 1;
               if (m_ecnt < 255) m_ecnt++;
            end
         end
         fv_hist[2] = fv_hist[1];
         fv_hist[1] = fv_hist[0];
         fv_hist[0] = fv;
      end
   endtask

   // driver: one clock edge, model update, compare #1 after the edge
   task automatic tick();
      @(posedge clk);
      model_step();
      exp_q.push_back(model_vec());
      #1;
      cyc++;
      check("scoreboard", dut_vec(), exp_q.pop_front());
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          rst;
      logic [3:0]  inc;
      bit          fv;
      bit          en;
      logic [13:0] exp;   // {clk,rise,fall,realign,early,locked,early_count}
   } vec_t;

   vec_t tbl[11];

   initial begin
      int r_cyc, c_cyc, n, n_early, n_tog;
      bit seen_r, seen_e;
      logic prev_clk;

      tbl[0]  = '{1'b1, 4'd8, 1'b0, 1'b1, {6'b000000, 8'd0}};
      tbl[1]  = '{1'b0, 4'd8, 1'b0, 1'b1, {6'b000000, 8'd0}};
      tbl[2]  = '{1'b0, 4'd8, 1'b0, 1'b1, {6'b110000, 8'd0}};
      tbl[3]  = '{1'b0, 4'd8, 1'b1, 1'b1, {6'b100000, 8'd0}};
      tbl[4]  = '{1'b0, 4'd8, 1'b1, 1'b1, {6'b001000, 8'd0}};
      tbl[5]  = '{1'b0, 4'd8, 1'b0, 1'b1, {6'b000010, 8'd1}};
      tbl[6]  = '{1'b0, 4'd8, 1'b0, 1'b1, {6'b110000, 8'd1}};
      tbl[7]  = '{1'b0, 4'd8, 1'b0, 1'b1, {6'b100000, 8'd1}};
      tbl[8]  = '{1'b0, 4'd8, 1'b0, 1'b1, {6'b001000, 8'd1}};
      tbl[9]  = '{1'b0, 4'd8, 1'b0, 1'b1, {6'b000000, 8'd1}};
      tbl[10] = '{1'b0, 4'd8, 1'b0, 1'b1, {6'b110000, 8'd1}};

      // free-run at inc=8 with an early fv pulse
      for (int i = 0; i < 11; i++) begin
         reset     = tbl[i].rst;
         inc       = tbl[i].inc;
         fv        = tbl[i].fv;
         resync_en = tbl[i].en;
         tick();
         check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
      end

      // inc=3: exactly 3 carries in every 16 cycles
      inc = 4'd3;
      for (int w = 0; w < 2; w++) begin
         n = 0;
         for (int i = 0; i < 16; i++) begin
            tick();
            if (pix_rise || pix_fall) n++;
         end
         check("inc3_carries", n, 3);
      end

      // accepted realignment after enough pixel periods
      inc = 4'd8;
      for (int i = 0; i < 14; i++) tick();
      fv = 1'b1;
      tick();
      fv = 1'b0;
      tick();
      tick();
      check("accept_realign", realign, 1);
      check("accept_early", early, 0);
      check("accept_pix_clk", pix_clk, 0);
      check("accept_locked", locked, 1);
      r_cyc = cyc;
      tick();
      check("after_realign_rise1", pix_rise, 0);
      tick();
      check("after_realign_rise2", {pix_rise, pix_clk}, 2'b11);

      // fv edge landing on a carry edge: realign wins
      while (cyc < r_cyc + 24) begin
         fv = ((cyc + 1) == (r_cyc + 22));
         tick();
         if (cyc == r_cyc + 23) check("collide_pre_clk", pix_clk, 1);
      end
      fv = 1'b0;
      check("collide_realign", realign, 1);
      check("collide_no_strobe", {pix_rise, pix_fall}, 2'b00);
      check("collide_pix_clk", pix_clk, 0);
      c_cyc = cyc;

      // loss of lock after LOSS pixel periods without realignment
      n = 0;
      while (locked && n < 80) begin
         tick();
         n++;
      end
      check("lock_loss_delay", cyc - c_cyc, 2 + 4 * (LOSS - 1) + 1);

      // resync disabled: fv pulses ignored entirely
      resync_en = 1'b0;
      seen_r = 0;
      seen_e = 0;
      for (int p = 0; p < 5; p++) begin
         fv = 1'b1;
         for (int i = 0; i < 2; i++) begin
            tick(); seen_r |= realign; seen_e |= early;
         end
         fv = 1'b0;
         for (int i = 0; i < 3; i++) begin
            tick(); seen_r |= realign; seen_e |= early;
         end
      end
      check("disabled_realign", seen_r, 0);
      check("disabled_early", seen_e, 0);
      check("disabled_ecnt", early_count, 1);

      // relock, then reset mid-period
      resync_en = 1'b1;
      fv = 1'b1;
      tick();
      fv = 1'b0;
      tick();
      tick();
      check("relock", {realign, locked}, 2'b11);
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_outputs", {pix_clk, pix_rise, pix_fall, realign, early, locked}, 6'b0);
      check("reset_ecnt", early_count, 0);
      tick();
      tick();
      fv = 1'b1;
      tick();
      fv = 1'b0;
      tick();
      tick();
      check("first_fv_rejected", {realign, early, early_count}, {2'b01, 8'd1});

      // saturation of the early counter with the NCO held static
      inc = 4'd0;
      n_early = 0;
      n_tog = 0;
      prev_clk = pix_clk;
      for (int p = 0; p < 300; p++) begin
         for (int i = 0; i < 4; i++) begin
            fv = (i < 2);
            tick();
            if (early) n_early++;
            if (pix_clk != prev_clk) n_tog++;
            prev_clk = pix_clk;
         end
      end
      fv = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("sat_ecnt", early_count, 255);
      check("sat_early_pulses", n_early, 300);
      check("inc0_static", n_tog, 0);

      // random phase against the reference model
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 31) == 0) inc = ACC_W'($urandom_range(0, ACC_MOD - 1));
         if ($urandom_range(0, 5) == 0) fv = ~fv;
         resync_en = ($urandom_range(0, 19) != 0);
         reset = ($urandom_range(0, 499) == 0);
         tick();
      end
      reset = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
